tt_um_asiclab_addacc: RTL and testbench
=======================================

TT_UM_ASICLAB_ADDACC -- requirements
Module: tt_um_asiclab_addacc

Interface
REQ-001 Parameter WIDTH, default 4, operand width; legal range 1..4.
REQ-002 Parameter ACC_W, default 8, result/accumulator width; legal range WIDTH+1..8.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port ui_in, input, 8: operand A = ui_in[4+WIDTH-1:4]; operand B = ui_in[WIDTH-1:0]; other bits ignored.
REQ-006 Port uio_in, input, 8: [0] req; [2:1] mode; [3] ack; [4] clr; [7:5] ignored.
REQ-007 Port uo_out, output, 8: result register, zero-extended from ACC_W.
REQ-008 Port uio_out, output, 8: [4] ready; [5] done; [6] ovf (sticky); [7] drop (sticky); [3:0] = 0.
REQ-009 Port uio_oe, output, 8: constant 8'hF0.
REQ-010 Port ena, input, 1: ignored.

Function
REQ-011 req, ack and clr SHALL each pass through a two-flop synchronizer before use; req_rise = synced req high while its one-cycle-delayed copy is low.
REQ-012 FSM states: IDLE, EXEC, DONE; ready = (state==IDLE); done = (state==DONE).
REQ-013 IDLE: on req_rise, capture A, B and mode; go to EXEC.
REQ-014 EXEC: one cycle; update result, acc and ovf per mode; go to DONE.
REQ-015 DONE: hold result; go to IDLE on the first cycle synced ack is high.
REQ-016 Latency: req high at the pin before rising edge 1 -> done high and uo_out valid after rising edge 4; A, B and mode stable from req rise until done.
REQ-017 Mode 00 ADD: result = A+B (ACC_W bits); acc unchanged; ovf unaffected.
REQ-018 Mode 01 SUB: result = (A-B) mod 2^ACC_W; ovf set if A<B; acc unchanged.
REQ-019 Mode 10 ACC: acc = (acc+A+B) mod 2^ACC_W; result = new acc; ovf set on wrap.
REQ-020 Mode 11 SAT: acc = min(acc+A+B, 2^ACC_W-1); result = new acc; ovf set if clamped.
REQ-021 Internal sums use ACC_W+1 bits; ovf is never cleared by an operation.
REQ-022 req_rise in EXEC or DONE: ignored, drop set; captured operands and result unchanged.
REQ-023 Synced clr high, in any state: acc, result, ovf and drop -> 0; FSM -> IDLE.
REQ-024 clr and req_rise in the same cycle: clr wins; the request is discarded and drop is not set.
REQ-025 ack high in IDLE or EXEC has no effect; ack held high makes each DONE last exactly one cycle.

Reset
REQ-026 rst_n low SHALL asynchronously clear synchronizers, FSM (IDLE), acc, result, ovf and drop.
REQ-027 Outputs during reset: uo_out = 0; uio_out = 8'h10 (ready high); uio_oe = 8'hF0.
REQ-028 Reset mid-operation aborts the operation; no partial result survives.

Structure
REQ-029 Mode encodings (ADD/SUB/ACC/SAT) and FSM state encodings SHALL live in shared package asiclab_pkg.
REQ-030 Sub-module asiclab_sync2 (two-flop synchronizer, async active-low reset) SHALL be instantiated for req, ack and clr.
REQ-031 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration.

Verification (WIDTH=4, ACC_W=8)
REQ-032 ADD, A=7, B=9, req pulse -> done after edge 4; uo_out=0x10; ovf=0.
REQ-033 SUB, A=3, B=5 -> uo_out=0xFE; ovf=1; ovf stays 1 through a following ADD.
REQ-034 clr, then 9x ACC with A=B=15 -> after the 8th op uo_out=0xF0, ovf=0; after the 9th uo_out=0x0E, ovf=1.
REQ-035 acc=0xF0, SAT with A=B=15 -> uo_out=0xFF, ovf=1; repeat -> uo_out stays 0xFF.
REQ-036 Second req pulse while in DONE -> drop=1, uo_out unchanged; ack -> ready=1; clr -> drop=0, ovf=0, uo_out=0.
REQ-037 rst_n low during EXEC -> uo_out=0 and uio_out=0x10 immediately, without a clock edge; after release, the next ADD returns the correct sum.

Source files
------------

// File: rtl/asiclab_pkg.sv
// Shared encodings for the add/accumulate block.
// Holds the operation modes, FSM states and fixed output constants.
package asiclab_pkg;

    localparam int OPW_MAX   = 4;
    localparam int ACC_W_MAX = 8;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_SAT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/asiclab_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
// Ports: clk, rst_n (async active-low), d_i (async in), q_o (synced out).
module asiclab_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tt_um_asiclab_addacc.sv
// Handshaked add/sub/accumulate/saturate unit with sticky status flags.
// Ports: ui_in operands, uio_in controls, uo_out result, uio_out status.
module tt_um_asiclab_addacc
    import asiclab_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    if (WIDTH < 1 || WIDTH > OPW_MAX) begin : g_bad_width
        $error("WIDTH must be in 1..4");
    end
    if (ACC_W < WIDTH + 1 || ACC_W > ACC_W_MAX) begin : g_bad_acc_w
        $error("ACC_W must be in WIDTH+1..8");
    end

    // One spare bit so carries and borrows are visible.
    localparam int SW = ACC_W + 1;

    logic req_s;
    logic ack_s;
    logic clr_s;

    asiclab_sync2 u_sync_req (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (uio_in[0]),
        .q_o   (req_s)
    );

    asiclab_sync2 u_sync_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (uio_in[3]),
        .q_o   (ack_s)
    );

    asiclab_sync2 u_sync_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (uio_in[4]),
        .q_o   (clr_s)
    );

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;
    logic               req_dly_q;

    logic               req_rise;
    logic [SW-1:0]      sum_ab;
    logic [SW-1:0]      acc_sum;
    logic [SW-1:0]      diff;

    assign req_rise = req_s & ~req_dly_q;

    assign sum_ab  = SW'(a_q) + SW'(b_q);
    assign acc_sum = SW'(acc_q) + sum_ab;
    assign diff    = SW'(a_q) - SW'(b_q);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        // Clear beats everything, including a coincident request.
        if (clr_s) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            res_d   = '0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_rise) begin
                        a_d     = ui_in[4 +: WIDTH];
                        b_d     = ui_in[0 +: WIDTH];
                        mode_d  = mode_e'(uio_in[2:1]);
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    unique case (mode_q)
                        MODE_ADD: begin
                            res_d = sum_ab[ACC_W-1:0];
                        end
                        MODE_SUB: begin
                            res_d = diff[ACC_W-1:0];
                            if (a_q < b_q) ovf_d = 1'b1;
                        end
                        MODE_ACC: begin
                            acc_d = acc_sum[ACC_W-1:0];
                            res_d = acc_sum[ACC_W-1:0];
                            if (acc_sum[ACC_W]) ovf_d = 1'b1;
                        end
                        MODE_SAT: begin
                            if (acc_sum[ACC_W]) begin
                                acc_d = '1;
                                res_d = '1;
                                ovf_d = 1'b1;
                            end else begin
                                acc_d = acc_sum[ACC_W-1:0];
                                res_d = acc_sum[ACC_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                    if (req_rise) drop_d = 1'b1;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (req_rise) drop_d = 1'b1;
                    if (ack_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ADD;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= 1'b0;
            req_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            req_dly_q <= req_s;
        end
    end

    assign uo_out  = 8'(res_q);
    assign uio_out = {drop_q, ovf_q,
                      (state_q == ST_DONE),
                      (state_q == ST_IDLE),
                      4'b0000};
    assign uio_oe  = UIO_OE_VAL;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_asiclab_addacc.sv
// Directed bench for tt_um_asiclab_addacc (WIDTH=4, ACC_W=8).
// Drives handshakes on uio_in and checks uo_out/uio_out values.
module tb_tt_um_asiclab_addacc;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int n_checks;
    int n_fail;

    tt_um_asiclab_addacc #(
        .WIDTH (4),
        .ACC_W (8)
    ) dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire ready = uio_out[4];
    wire done  = uio_out[5];
    wire ovf   = uio_out[6];
    wire drop  = uio_out[7];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request; checks done is low after edge 3, high after 4.
    task automatic op(input logic [1:0] m,
                      input logic [3:0] a,
                      input logic [3:0] b,
                      input string tag);
        @(negedge clk);
        ui_in      = {a, b};
        uio_in[2:1] = m;
        uio_in[0]  = 1'b1;
        repeat (3) @(posedge clk);
        #1 check({tag, "_lat"}, 32'(done), 32'd0);
        @(posedge clk);
        #1 check({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        uio_in[0] = 1'b0;
    endtask

    task automatic ack_op(input string tag);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        uio_in[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, 32'(seen), 32'd1);
        @(negedge clk);
        uio_in[3] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input logic [1:0] m,
                       input logic [3:0] a,
                       input logic [3:0] b,
                       input string tag);
        op(m, a, b, tag);
        ack_op(tag);
    endtask

    task automatic clear;
        @(negedge clk);
        uio_in[4] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        uio_in[4] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        rst_n    = 1'b0;

        #23;
        check("rst_uo", 32'(uo_out), 32'h00);
        check("rst_uio", 32'(uio_out), 32'h10);
        check("rst_oe", 32'(uio_oe), 32'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        op(2'b00, 4'd7, 4'd9, "add");
        check("add_uo", 32'(uo_out), 32'h10);
        check("add_ovf", 32'(ovf), 32'd0);
        ack_op("add");

        op(2'b01, 4'd3, 4'd5, "sub");
        check("sub_uo", 32'(uo_out), 32'hFE);
        check("sub_ovf", 32'(ovf), 32'd1);
        ack_op("sub");

        run(2'b00, 4'd1, 4'd2, "add2");
        check("add2_uo", 32'(uo_out), 32'h03);
        check("add2_ovf", 32'(ovf), 32'd1);

        clear();
        check("clr_uo", 32'(uo_out), 32'h00);
        check("clr_ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 8; i++) run(2'b10, 4'd15, 4'd15, "acc");
        check("acc8_uo", 32'(uo_out), 32'hF0);
        check("acc8_ovf", 32'(ovf), 32'd0);
        run(2'b10, 4'd15, 4'd15, "acc9");
        check("acc9_uo", 32'(uo_out), 32'h0E);
        check("acc9_ovf", 32'(ovf), 32'd1);

        clear();
        for (int i = 0; i < 8; i++) run(2'b10, 4'd15, 4'd15, "pre");
        check("pre_uo", 32'(uo_out), 32'hF0);
        check("pre_ovf", 32'(ovf), 32'd0);
        run(2'b11, 4'd15, 4'd15, "sat1");
        check("sat1_uo", 32'(uo_out), 32'hFF);
        check("sat1_ovf", 32'(ovf), 32'd1);
        run(2'b11, 4'd15, 4'd15, "sat2");
        check("sat2_uo", 32'(uo_out), 32'hFF);

        // Second request while waiting in DONE.
        op(2'b00, 4'd1, 4'd1, "drp");
        repeat (2) @(negedge clk);
        ui_in     = 8'hFF;
        uio_in[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drp_flag", 32'(drop), 32'd1);
        check("drp_uo", 32'(uo_out), 32'h02);
        check("drp_done", 32'(done), 32'd1);
        @(negedge clk);
        uio_in[0] = 1'b0;
        ack_op("drp");
        check("drp_rdy", 32'(ready), 32'd1);
        clear();
        check("drpc_drop", 32'(drop), 32'd0);
        check("drpc_ovf", 32'(ovf), 32'd0);
        check("drpc_uo", 32'(uo_out), 32'h00);

        // Reset in the middle of an operation.
        run(2'b00, 4'd2, 4'd3, "pre_rst");
        check("pre_rst_uo", 32'(uo_out), 32'h05);
        @(negedge clk);
        ui_in       = 8'h44;
        uio_in[2:1] = 2'b00;
        uio_in[0]   = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("exec_rdy", 32'(ready), 32'd0);
        #1;
        rst_n     = 1'b0;
        uio_in[0] = 1'b0;
        #1;
        check("arst_uo", 32'(uo_out), 32'h00);
        check("arst_uio", 32'(uio_out), 32'h10);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        op(2'b00, 4'd4, 4'd6, "post");
        check("post_uo", 32'(uo_out), 32'h0A);
        ack_op("post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
